// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: redirect inputs, backend stall and the fetch request channel.
// A request transfers on any clock edge where req_valid_o & req_ready_i are both high; once
// req_valid_o is high, it and req_addr_o/req_epoch_o stay stable until that transfer.
interface fetch_pc_gen_if #(
  parameter int XLEN    = 64,
  parameter int EPOCH_W = 2
);
  logic               stall_i;
  logic               clint_valid_i;
  logic [XLEN-1:0]    clint_pc_i;
  logic               flush_valid_i;
  logic [XLEN-1:0]    flush_pc_i;
  logic               branch_valid_i;
  logic [XLEN-1:0]    branch_pc_i;
  logic               bpu_valid_i;
  logic [XLEN-1:0]    bpu_pc_i;
  logic               req_valid_o;
  logic               req_ready_i;
  logic [XLEN-1:0]    req_addr_o;
  logic [EPOCH_W-1:0] req_epoch_o;
  logic [XLEN-1:0]    pc_o;
  logic [EPOCH_W-1:0] cur_epoch_o;
  logic               misalign_o;
  logic [1:0]         dbg_state_o;

  modport master (
    input  stall_i,
    input  clint_valid_i, clint_pc_i,
    input  flush_valid_i, flush_pc_i,
    input  branch_valid_i, branch_pc_i,
    input  bpu_valid_i, bpu_pc_i,
    input  req_ready_i,
    output req_valid_o, req_addr_o, req_epoch_o,
    output pc_o, cur_epoch_o, misalign_o,
    output dbg_state_o
  );

  modport slave (
    output stall_i,
    output clint_valid_i, clint_pc_i,
    output flush_valid_i, flush_pc_i,
    output branch_valid_i, branch_pc_i,
    output bpu_valid_i, bpu_pc_i,
    output req_ready_i,
    input  req_valid_o, req_addr_o, req_epoch_o,
    input  pc_o, cur_epoch_o, misalign_o,
    input  dbg_state_o
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: prioritised redirects, epoch tagging, and a held fetch request that
// parks any redirect arriving mid-hold in a pending register until the request transfers.
module fetch_pc_gen #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_ADDR  = XLEN'(64'h8000_0000),
  parameter int              FETCH_BYTES = 4,
  parameter int              C_EXT       = 1,
  parameter int              EPOCH_W     = 2
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_gen_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] BLK_MASK  = ~XLEN'(FETCH_BYTES - 1);
  localparam logic [XLEN-1:0] FETCH_INC = XLEN'(FETCH_BYTES);

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    pend_pc_q, pend_pc_d;
  logic               pend_valid_q, pend_valid_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [EPOCH_W-1:0] req_epoch_q, req_epoch_d;
  logic               misalign_q, misalign_d;

  logic               req_valid;
  logic               hold_now;
  logic               xfer;
  logic               redir_any;
  logic [XLEN-1:0]    redir_raw;
  logic [XLEN-1:0]    redir_tgt;
  logic               redir_bad;
  logic [XLEN-1:0]    seq_pc;

  // Fixed priority: trap, flush, branch, predictor.
  always_comb begin
    redir_any = bus.clint_valid_i | bus.flush_valid_i | bus.branch_valid_i | bus.bpu_valid_i;
    redir_raw = '0;
    if (bus.clint_valid_i)       redir_raw = bus.clint_pc_i;
    else if (bus.flush_valid_i)  redir_raw = bus.flush_pc_i;
    else if (bus.branch_valid_i) redir_raw = bus.branch_pc_i;
    else if (bus.bpu_valid_i)    redir_raw = bus.bpu_pc_i;
  end

  always_comb begin
    redir_tgt    = redir_raw;
    redir_tgt[0] = 1'b0;
    redir_bad    = 1'b0;
    if (C_EXT == 0) begin
      redir_tgt[1] = 1'b0;
      redir_bad    = redir_raw[1];
    end
  end

  assign seq_pc = (pc_q & BLK_MASK) + FETCH_INC;

  // FSM output process
  always_comb begin
    req_valid = 1'b0;
    case (state_q)
      ST_RUN:  req_valid = ~bus.stall_i;
      ST_HOLD: req_valid = 1'b1;
      default: req_valid = 1'b0;
    endcase
  end

  assign hold_now = req_valid & ~bus.req_ready_i;
  assign xfer     = req_valid & bus.req_ready_i;

  // FSM next-state process
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (hold_now) state_d = ST_HOLD;
      ST_HOLD: if (bus.req_ready_i) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // A redirect seen while the presented request is unaccepted must not disturb it,
  // so it is parked; a redirect on the accepting cycle itself supersedes any parked one.
  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    epoch_d      = epoch_q;
    req_epoch_d  = req_epoch_q;
    misalign_d   = 1'b0;

    if (redir_any) begin
      epoch_d    = epoch_q + EPOCH_W'(1);
      misalign_d = redir_bad;
      if (hold_now) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = redir_tgt;
      end else begin
        pc_d         = redir_tgt;
        pend_valid_d = 1'b0;
      end
    end else if (xfer) begin
      pc_d         = pend_valid_q ? pend_pc_q : seq_pc;
      pend_valid_d = 1'b0;
    end

    if (req_valid && (state_q != ST_HOLD)) req_epoch_d = epoch_q;
  end

  // FSM state register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_ADDR;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      epoch_q      <= '0;
      req_epoch_q  <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      epoch_q      <= epoch_d;
      req_epoch_q  <= req_epoch_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.req_valid_o = req_valid;
  assign bus.req_addr_o  = pc_q & BLK_MASK;
  assign bus.req_epoch_o = (state_q == ST_HOLD) ? req_epoch_q : epoch_q;
  assign bus.pc_o        = pc_q;
  assign bus.cur_epoch_o = epoch_q;
  assign bus.misalign_o  = misalign_q;
  assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: cycle vector table through an expected-value queue, plus
// hand sequences for priority, sanitising, C_EXT=0 misalignment and reset mid-hold.
module tb_fetch_pc_gen;
  localparam int XLEN  = 64;
  localparam int EW    = 2;
  localparam int EXP_W = 1 + XLEN + EW + XLEN + EW + 1;
  localparam logic [XLEN-1:0] RA = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  fetch_pc_gen_if #(.XLEN(XLEN), .EPOCH_W(EW)) bus ();
  fetch_pc_gen_if #(.XLEN(XLEN), .EPOCH_W(EW)) bus_nc ();

  fetch_pc_gen #(.XLEN(XLEN), .RESET_ADDR(RA), .FETCH_BYTES(4), .C_EXT(1), .EPOCH_W(EW))
    dut (.clk(clk), .rst(rst), .bus(bus.master));

  fetch_pc_gen #(.XLEN(XLEN), .RESET_ADDR(RA), .FETCH_BYTES(4), .C_EXT(0), .EPOCH_W(EW))
    dut_nc (.clk(clk), .rst(rst), .bus(bus_nc.master));

  typedef struct {
    logic            stall;
    logic            ready;
    logic [3:0]      rmask;   // {clint, flush, branch, bpu}
    logic [XLEN-1:0] rtgt;
    logic            e_valid;
    logic [XLEN-1:0] e_addr;
    logic [EW-1:0]   e_repoch;
    logic [XLEN-1:0] e_pc;
    logic [EW-1:0]   e_cepoch;
  } vec_t;

  vec_t tbl[25];
  logic [EXP_W-1:0] exp_q[$];

  function automatic vec_t v(input logic s, input logic r, input logic [3:0] m,
                             input logic [XLEN-1:0] t, input logic ev,
                             input logic [XLEN-1:0] ea, input logic [EW-1:0] ere,
                             input logic [XLEN-1:0] epc, input logic [EW-1:0] ece);
    vec_t x;
    x.stall = s; x.ready = r; x.rmask = m; x.rtgt = t;
    x.e_valid = ev; x.e_addr = ea; x.e_repoch = ere; x.e_pc = epc; x.e_cepoch = ece;
    return x;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // driver: the winning source gets the target, losing sources get a scrambled address
  task automatic drive(input logic s, input logic r, input logic [3:0] m, input logic [XLEN-1:0] t);
    int win;
    win = -1;
    for (int k = 0; k < 4; k++) if (m[3-k] && win < 0) win = k;
    bus.stall_i        = s;
    bus.req_ready_i    = r;
    bus.clint_valid_i  = m[3];
    bus.flush_valid_i  = m[2];
    bus.branch_valid_i = m[1];
    bus.bpu_valid_i    = m[0];
    bus.clint_pc_i     = (win == 0) ? t : (t ^ 64'h5550);
    bus.flush_pc_i     = (win == 1) ? t : (t ^ 64'h5550);
    bus.branch_pc_i    = (win == 2) ? t : (t ^ 64'h5550);
    bus.bpu_pc_i       = (win == 3) ? t : (t ^ 64'h5550);
  endtask

  task automatic expect_out(input logic ev, input logic [XLEN-1:0] ea, input logic [EW-1:0] ere,
                            input logic [XLEN-1:0] epc, input logic [EW-1:0] ece, input logic emis);
    exp_q.push_back({ev, ea, ere, epc, ece, emis});
  endtask

  // scoreboard: pop one expectation and compare against the main DUT outputs
  task automatic check_out(input string tag);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL %s: got empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " valid"},     XLEN'(bus.req_valid_o), XLEN'(e[EXP_W-1]));
      chk({tag, " addr"},      bus.req_addr_o,         e[EXP_W-2 -: XLEN]);
      chk({tag, " req_epoch"}, XLEN'(bus.req_epoch_o), XLEN'(e[EXP_W-2-XLEN -: EW]));
      chk({tag, " pc"},        bus.pc_o,               e[EXP_W-2-XLEN-EW -: XLEN]);
      chk({tag, " cur_epoch"}, XLEN'(bus.cur_epoch_o), XLEN'(e[EW : 1]));
      chk({tag, " misalign"},  XLEN'(bus.misalign_o),  XLEN'(e[0]));
    end
  endtask

  task automatic apply_row(input int i, input string tag);
    drive(tbl[i].stall, tbl[i].ready, tbl[i].rmask, tbl[i].rtgt);
    expect_out(tbl[i].e_valid, tbl[i].e_addr, tbl[i].e_repoch, tbl[i].e_pc, tbl[i].e_cepoch, 1'b0);
    #1;
    check_out($sformatf("%s%0d", tag, i));
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = v(0, 1, 4'h0, 64'h0,         0, 64'h8000_0000, 0, 64'h8000_0000, 0);
    tbl[1]  = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_0000, 0, 64'h8000_0000, 0);
    tbl[2]  = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_0004, 0, 64'h8000_0004, 0);
    tbl[3]  = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_0008, 0, 64'h8000_0008, 0);
    tbl[4]  = v(0, 1, 4'h2, 64'h8000_0102, 1, 64'h8000_000C, 0, 64'h8000_000C, 0);
    tbl[5]  = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_0100, 1, 64'h8000_0102, 1);
    tbl[6]  = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_0104, 1, 64'h8000_0104, 1);
    tbl[7]  = v(0, 0, 4'h0, 64'h0,         1, 64'h8000_0108, 1, 64'h8000_0108, 1);
    tbl[8]  = v(1, 0, 4'h0, 64'h0,         1, 64'h8000_0108, 1, 64'h8000_0108, 1);
    tbl[9]  = v(1, 0, 4'h0, 64'h0,         1, 64'h8000_0108, 1, 64'h8000_0108, 1);
    tbl[10] = v(1, 1, 4'h0, 64'h0,         1, 64'h8000_0108, 1, 64'h8000_0108, 1);
    tbl[11] = v(1, 1, 4'h0, 64'h0,         0, 64'h8000_010C, 1, 64'h8000_010C, 1);
    tbl[12] = v(1, 1, 4'h0, 64'h0,         0, 64'h8000_010C, 1, 64'h8000_010C, 1);
    tbl[13] = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_010C, 1, 64'h8000_010C, 1);
    tbl[14] = v(0, 0, 4'h0, 64'h0,         1, 64'h8000_0110, 1, 64'h8000_0110, 1);
    tbl[15] = v(0, 0, 4'h2, 64'h8000_1000, 1, 64'h8000_0110, 1, 64'h8000_0110, 1);
    tbl[16] = v(0, 0, 4'h8, 64'h8000_2000, 1, 64'h8000_0110, 1, 64'h8000_0110, 2);
    tbl[17] = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_0110, 1, 64'h8000_0110, 3);
    tbl[18] = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_2000, 3, 64'h8000_2000, 3);
    tbl[19] = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_2004, 3, 64'h8000_2004, 3);
    tbl[20] = v(0, 0, 4'h1, 64'h8000_3002, 1, 64'h8000_2008, 3, 64'h8000_2008, 3);
    tbl[21] = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_2008, 3, 64'h8000_2008, 0);
    tbl[22] = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_3000, 0, 64'h8000_3002, 0);
    tbl[23] = v(1, 0, 4'h4, 64'h8000_4000, 0, 64'h8000_3004, 0, 64'h8000_3004, 0);
    tbl[24] = v(0, 1, 4'h0, 64'h0,         1, 64'h8000_4000, 1, 64'h8000_4000, 1);

    drive(1'b0, 1'b1, 4'h0, '0);
    bus_nc.stall_i        = 1'b1;
    bus_nc.req_ready_i    = 1'b1;
    bus_nc.clint_valid_i  = 1'b0; bus_nc.clint_pc_i  = '0;
    bus_nc.flush_valid_i  = 1'b0; bus_nc.flush_pc_i  = '0;
    bus_nc.branch_valid_i = 1'b0; bus_nc.branch_pc_i = '0;
    bus_nc.bpu_valid_i    = 1'b0; bus_nc.bpu_pc_i    = '0;

    repeat (3) @(negedge clk);
    expect_out(1'b0, RA, 2'd0, RA, 2'd0, 1'b0);
    check_out("reset");
    chk("nc reset pc", bus_nc.pc_o, RA);

    rst = 1'b0;
    for (int i = 0; i < 25; i++) apply_row(i, "row");

    // all four redirects at once: trap wins
    drive(1'b0, 1'b1, 4'h0, '0);
    bus.clint_valid_i = 1'b1;  bus.clint_pc_i  = 64'h100;
    bus.flush_valid_i = 1'b1;  bus.flush_pc_i  = 64'h200;
    bus.branch_valid_i = 1'b1; bus.branch_pc_i = 64'h300;
    bus.bpu_valid_i = 1'b1;    bus.bpu_pc_i    = 64'h400;
    expect_out(1'b1, 64'h8000_4004, 2'd1, 64'h8000_4004, 2'd1, 1'b0);
    #1 check_out("prio_drive");
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h0, '0);
    expect_out(1'b1, 64'h100, 2'd2, 64'h100, 2'd2, 1'b0);
    #1 check_out("prio_after");
    @(negedge clk);

    // odd target with C_EXT=1: bit0 cleared, no misalign
    drive(1'b0, 1'b1, 4'h2, 64'h8000_0103);
    expect_out(1'b1, 64'h104, 2'd2, 64'h104, 2'd2, 1'b0);
    #1 check_out("odd_drive");
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h0, '0);
    expect_out(1'b1, 64'h8000_0100, 2'd3, 64'h8000_0102, 2'd3, 1'b0);
    #1 check_out("odd_after");
    @(negedge clk);

    // reset while holding a request with a parked redirect
    drive(1'b0, 1'b0, 4'h2, 64'h8000_5000);
    expect_out(1'b1, 64'h8000_0104, 2'd3, 64'h8000_0104, 2'd3, 1'b0);
    #1 check_out("rsthold_a");
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, '0);
    expect_out(1'b1, 64'h8000_0104, 2'd3, 64'h8000_0104, 2'd0, 1'b0);
    #1 check_out("rsthold_b");
    rst = 1'b1;
    expect_out(1'b0, RA, 2'd0, RA, 2'd0, 1'b0);
    #1 check_out("rsthold_async");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) apply_row(i, "replay");
    drive(1'b0, 1'b1, 4'h0, '0);
    expect_out(1'b1, 64'h8000_000C, 2'd0, 64'h8000_000C, 2'd0, 1'b0);
    #1 check_out("replay_post");
    @(negedge clk);

    // C_EXT=0 instance: bit1 set raises misalign for one cycle
    bus_nc.branch_valid_i = 1'b1; bus_nc.branch_pc_i = 64'h8000_0006;
    @(negedge clk);
    bus_nc.branch_valid_i = 1'b0;
    #1;
    chk("nc pc after 0x..06", bus_nc.pc_o, 64'h8000_0004);
    chk("nc misalign pulse", XLEN'(bus_nc.misalign_o), 64'h1);
    chk("nc epoch", XLEN'(bus_nc.cur_epoch_o), 64'h1);
    @(negedge clk);
    #1 chk("nc misalign drop", XLEN'(bus_nc.misalign_o), 64'h0);
    @(negedge clk);
    bus_nc.bpu_valid_i = 1'b1; bus_nc.bpu_pc_i = 64'h8000_0009;
    @(negedge clk);
    bus_nc.bpu_valid_i = 1'b0;
    #1;
    chk("nc pc after 0x..09", bus_nc.pc_o, 64'h8000_0008);
    chk("nc no misalign", XLEN'(bus_nc.misalign_o), 64'h0);
    chk("nc valid stalled", XLEN'(bus_nc.req_valid_o), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
